// File: rtl/ingress_classifier.sv
// Ingress classifier: steers a valid/ready word stream into four FIFOs by class bits,
// through a 2-entry in-order buffer. Optional INGRESS_PARITY_EN adds input parity checking.
module ingress_classifier #(
   parameter int DATA_W    = 10,
   parameter int CLASS_MSB = 9,
   parameter int CNT_W     = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
`ifdef INGRESS_PARITY_EN
   input  logic              in_parity,
   output logic [CNT_W-1:0]  par_err_cnt,
`endif
   output logic              in_ready,
   input  logic              almost_full_P0,
   input  logic              almost_full_P1,
   input  logic              almost_full_P2,
   input  logic              almost_full_P3,
   output logic              push_F0,
   output logic              push_F1,
   output logic              push_F2,
   output logic              push_F3,
   output logic [DATA_W-1:0] fifo_data,
   output logic [CNT_W-1:0]  cnt_F0,
   output logic [CNT_W-1:0]  cnt_F1,
   output logic [CNT_W-1:0]  cnt_F2,
   output logic [CNT_W-1:0]  cnt_F3,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Even parity: the parity bit makes the total count of ones even.
   function automatic logic f_par_ok(input logic [DATA_W-1:0] d, input logic p);
      return ((^d) == p);
   endfunction

   state_t            r_state;
   logic [DATA_W-1:0] r_head;
   logic [DATA_W-1:0] r_skid;
   logic [DATA_W-1:0] r_fifo_data;
   logic [3:0]        r_push;
   logic [CNT_W-1:0]  r_cnt [4];
   logic [CNT_W-1:0]  r_stall;

   logic [3:0]        w_af;
   logic [1:0]        w_cls;
   logic              w_head_vld;
   logic              w_dsp;
   logic              w_hs;
   logic              w_par_ok;
   logic              w_acc;

   assign w_af       = {almost_full_P3, almost_full_P2, almost_full_P1, almost_full_P0};
   assign w_cls      = r_head[CLASS_MSB -: 2];
   assign w_head_vld = (r_state != ST_EMPTY);
   assign w_dsp      = w_head_vld & ~w_af[w_cls];
   assign in_ready   = reset & (r_state != ST_FULL);
   assign w_hs       = in_valid & in_ready;

`ifdef INGRESS_PARITY_EN
   logic [CNT_W-1:0] r_par_err;
   assign w_par_ok    = f_par_ok(in_data, in_parity);
   assign par_err_cnt = r_par_err;

   // Count discarded words with bad parity, saturating.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_par_err <= {CNT_W{1'b0}};
      end else if (w_hs && !w_par_ok && (r_par_err != CNT_MAX)) begin
         r_par_err <= r_par_err + CNT_ONE;
      end else begin
         r_par_err <= r_par_err;
      end
   end
`else
   assign w_par_ok = 1'b1;
`endif

   assign w_acc = w_hs & w_par_ok;

   // Buffer occupancy FSM with head/skid registers and the registered push outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_EMPTY;
         r_head      <= {DATA_W{1'b0}};
         r_skid      <= {DATA_W{1'b0}};
         r_fifo_data <= {DATA_W{1'b0}};
         r_push      <= 4'b0000;
      end else begin
         r_push <= w_dsp ? (4'b0001 << w_cls) : 4'b0000;
         if (w_dsp) begin
            r_fifo_data <= r_head;
         end else begin
            r_fifo_data <= r_fifo_data;
         end
         case (r_state)
            ST_EMPTY: begin
               if (w_acc) begin
                  r_head  <= in_data;
                  r_state <= ST_ONE;
               end else begin
                  r_state <= ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (w_acc && w_dsp) begin
                  r_head  <= in_data;
                  r_state <= ST_ONE;
               end else if (w_acc) begin
                  r_skid  <= in_data;
                  r_state <= ST_FULL;
               end else if (w_dsp) begin
                  r_state <= ST_EMPTY;
               end else begin
                  r_state <= ST_ONE;
               end
            end
            ST_FULL: begin
               if (w_dsp) begin
                  r_head  <= r_skid;
                  r_state <= ST_ONE;
               end else begin
                  r_state <= ST_FULL;
               end
            end
            default: begin
               r_state <= ST_EMPTY;
            end
         endcase
      end
   end

   // Per-class push counters (wrapping) and head-of-line stall counter (saturating).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) begin
            r_cnt[i] <= {CNT_W{1'b0}};
         end
         r_stall <= {CNT_W{1'b0}};
      end else begin
         if (w_dsp) begin
            r_cnt[w_cls] <= r_cnt[w_cls] + CNT_ONE;
         end else begin
            r_cnt[w_cls] <= r_cnt[w_cls];
         end
         if (w_head_vld && !w_dsp && (r_stall != CNT_MAX)) begin
            r_stall <= r_stall + CNT_ONE;
         end else begin
            r_stall <= r_stall;
         end
      end
   end

   assign push_F0   = r_push[0];
   assign push_F1   = r_push[1];
   assign push_F2   = r_push[2];
   assign push_F3   = r_push[3];
   assign fifo_data = r_fifo_data;
   assign cnt_F0    = r_cnt[0];
   assign cnt_F1    = r_cnt[1];
   assign cnt_F2    = r_cnt[2];
   assign cnt_F3    = r_cnt[3];
   assign stall_cnt = r_stall;

endmodule

// File: tb/tb_ingress_classifier.sv
// Scoreboard bench for ingress_classifier: a queue-based reference model predicts pushes,
// a separate monitor checks every push strobe and fifo_data against the expectation queue.
module tb_ingress_classifier;
   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [9:0] in_data;
   logic       in_ready;
   logic       almost_full_P0, almost_full_P1, almost_full_P2, almost_full_P3;
   logic       push_F0, push_F1, push_F2, push_F3;
   logic [9:0] fifo_data;
   logic [7:0] cnt_F0, cnt_F1, cnt_F2, cnt_F3, stall_cnt;
`ifdef INGRESS_PARITY_EN
   logic       in_parity;
   logic [7:0] par_err_cnt;
`endif

   always #5 clk = ~clk;

   ingress_classifier dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
`ifdef INGRESS_PARITY_EN
      .in_parity(in_parity), .par_err_cnt(par_err_cnt),
`endif
      .in_ready(in_ready),
      .almost_full_P0(almost_full_P0), .almost_full_P1(almost_full_P1),
      .almost_full_P2(almost_full_P2), .almost_full_P3(almost_full_P3),
      .push_F0(push_F0), .push_F1(push_F1), .push_F2(push_F2), .push_F3(push_F3),
      .fifo_data(fifo_data),
      .cnt_F0(cnt_F0), .cnt_F1(cnt_F1), .cnt_F2(cnt_F2), .cnt_F3(cnt_F3),
      .stall_cnt(stall_cnt)
   );

   typedef struct {
      logic [9:0] data;
      int         cyc;
   } exp_t;

   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   exp_t       exp_q[$];
   logic [9:0] mq[$];
   int         m_cnt[4];
   int         m_stall = 0;
   int         m_perr  = 0;
   logic       last_acc;
   logic [9:0] exp_fd = 10'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_stats();
      check("cnt_F0", 32'(cnt_F0), m_cnt[0]);
      check("cnt_F1", 32'(cnt_F1), m_cnt[1]);
      check("cnt_F2", 32'(cnt_F2), m_cnt[2]);
      check("cnt_F3", 32'(cnt_F3), m_cnt[3]);
      check("stall_cnt", 32'(stall_cnt), m_stall);
`ifdef INGRESS_PARITY_EN
      check("par_err_cnt", 32'(par_err_cnt), m_perr);
`endif
   endtask

   // One clock of stimulus; the model predicts what the next rising edge does.
   task automatic step(input logic v, input logic [9:0] d, input logic [3:0] af, input logic perr);
      logic [9:0] h;
      logic [1:0] c;
      exp_t       e;
      logic       acc;
      @(negedge clk); #1;
      in_valid = v;
      in_data  = d;
      {almost_full_P3, almost_full_P2, almost_full_P1, almost_full_P0} = af;
`ifdef INGRESS_PARITY_EN
      in_parity = (^d) ^ perr;
`endif
      check("in_ready", 32'(in_ready), 32'(reset && (mq.size() < 2)));
      check_stats();
      acc = v && reset && (mq.size() < 2);
      last_acc = acc;
      if (mq.size() > 0) begin
         h = mq[0];
         c = h[9:8];
         if (!af[c]) begin
            e.data = h;
            e.cyc  = cyc;
            exp_q.push_back(e);
            m_cnt[c] = (m_cnt[c] + 1) % 256;
            void'(mq.pop_front());
         end else if (m_stall < 255) begin
            m_stall++;
         end
      end
      if (acc) begin
`ifdef INGRESS_PARITY_EN
         if (perr) begin
            if (m_perr < 255) m_perr++;
         end else begin
            mq.push_back(d);
         end
`else
         if (!perr) mq.push_back(d);
`endif
      end
   endtask

   // Keep offering a word until the model says it was taken (bounded).
   task automatic send_until_acc(input logic [9:0] d, input logic [3:0] af);
      int n = 0;
      last_acc = 1'b0;
      while (!last_acc && n < 50) begin
         step(1'b1, d, af, 1'b0);
         n++;
      end
      check("accept_timeout", 32'(last_acc), 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk); #1;
      reset    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("rst_push", 32'({push_F3, push_F2, push_F1, push_F0}), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_fifo_data", 32'(fifo_data), 32'd0);
      mq.delete();
      exp_q.delete();
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_stall = 0;
      m_perr  = 0;
      check_stats();
      repeat (2) @(negedge clk);
      #1;
      reset = 1'b1;
   endtask

   // Monitor: consumes the expectation queue whenever a push strobe is seen.
   initial begin
      logic [3:0] pv;
      exp_t       e;
      forever begin
         @(negedge clk);
         pv = {push_F3, push_F2, push_F1, push_F0};
         if (!reset) begin
            check("push_during_reset", 32'(pv), 32'd0);
            exp_fd = 10'd0;
         end else if (pv != 4'd0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_push", 32'(pv), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("push_cycle", cyc, e.cyc + 1);
               check("push_strobe", 32'(pv), 32'd1 << e.data[9:8]);
               check("push_data", 32'(fifo_data), 32'(e.data));
               exp_fd = e.data;
            end
         end else begin
            if (exp_q.size() > 0 && exp_q[0].cyc + 1 <= cyc) begin
               e = exp_q.pop_front();
               check("missing_push", 32'(pv), 32'd1 << e.data[9:8]);
            end
            check("fifo_data_hold", 32'(fifo_data), 32'(exp_fd));
         end
      end
   end

   initial begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      reset    = 1'b0;
      in_valid = 1'b0;
      in_data  = 10'd0;
      {almost_full_P3, almost_full_P2, almost_full_P1, almost_full_P0} = 4'b0000;
`ifdef INGRESS_PARITY_EN
      in_parity = 1'b0;
`endif
      #12;
      check("reset_in_ready", 32'(in_ready), 32'd0);
      check("reset_fifo_data", 32'(fifo_data), 32'd0);
      check_stats();
      @(negedge clk); #1;
      reset = 1'b1;

      // One word per class, back to back.
      step(1'b1, 10'h000, 4'b0000, 1'b0);
      step(1'b1, 10'h100, 4'b0000, 1'b0);
      step(1'b1, 10'h200, 4'b0000, 1'b0);
      step(1'b1, 10'h300, 4'b0000, 1'b0);
      repeat (3) step(1'b0, 10'h000, 4'b0000, 1'b0);

      // Head-of-line blocking on FIFO 2.
      step(1'b1, 10'h2AA, 4'b0100, 1'b0);
      step(1'b1, 10'h011, 4'b0100, 1'b0);
      repeat (3) step(1'b1, 10'h3FF, 4'b0100, 1'b0);
      send_until_acc(10'h3FF, 4'b0000);
      repeat (4) step(1'b0, 10'h000, 4'b0000, 1'b0);

      // almost_full rises exactly when the head becomes dispatchable.
      step(1'b1, 10'h155, 4'b0000, 1'b0);
      step(1'b0, 10'h000, 4'b0010, 1'b0);
      step(1'b0, 10'h000, 4'b0010, 1'b0);
      repeat (3) step(1'b0, 10'h000, 4'b0000, 1'b0);

      // Randomized traffic and back-pressure.
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 3) != 0, 10'($urandom),
              {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0}, 1'b0);
      end
      repeat (4) step(1'b0, 10'h000, 4'b0000, 1'b0);

      // Enough class-0 words to wrap the counter.
      for (int i = 0; i < 260; i++) step(1'b1, {2'b00, 8'($urandom)}, 4'b0000, 1'b0);
      repeat (4) step(1'b0, 10'h000, 4'b0000, 1'b0);

      // Long stall to saturate stall_cnt.
      send_until_acc(10'h0C3, 4'b0001);
      repeat (300) step(1'b0, 10'h000, 4'b0001, 1'b0);
      repeat (4) step(1'b0, 10'h000, 4'b0000, 1'b0);

`ifdef INGRESS_PARITY_EN
      step(1'b1, 10'h001, 4'b0000, 1'b1);
      step(1'b1, 10'h003, 4'b0000, 1'b0);
      repeat (4) step(1'b0, 10'h000, 4'b0000, 1'b0);
`endif

      // Reset while push_F3 is high and a word is buffered.
      step(1'b1, 10'h3AB, 4'b0000, 1'b0);
      step(1'b1, 10'h100, 4'b0010, 1'b0);
      do_reset();
      repeat (6) step(1'b0, 10'h000, 4'b0000, 1'b0);
      step(1'b1, 10'h2C1, 4'b0000, 1'b0);
      repeat (4) step(1'b0, 10'h000, 4'b0000, 1'b0);

      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
